// File: rtl/register_file_2r1w_if.sv
// rtl/register_file_2r1w_if.sv - write, dual-read and clear signals of the 2R1W register file
interface register_file_2r1w_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  re_a;
    logic [ADDR_WIDTH-1:0] raddr_a;
    logic [DATA_WIDTH-1:0] rdata_a;
    logic                  re_b;
    logic [ADDR_WIDTH-1:0] raddr_b;
    logic [DATA_WIDTH-1:0] rdata_b;
    logic                  clr_req;
    logic                  busy;

    modport master (
        output we, waddr, wdata, re_a, raddr_a, re_b, raddr_b, clr_req,
        input  rdata_a, rdata_b, busy
    );

    modport slave (
        input  we, waddr, wdata, re_a, raddr_a, re_b, raddr_b, clr_req,
        output rdata_a, rdata_b, busy
    );
endinterface

// File: rtl/register_file_2r1w.sv
// rtl/register_file_2r1w.sv - 2-read/1-write register file with write-first bypass and clear engine (option: REGFILE_ZERO_REG_EN)
module register_file_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    register_file_2r1w_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] counter;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_a_q;
    logic [DATA_WIDTH-1:0] rdata_b_q;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;
    logic                  clr_start;
    logic                  clr_active;
    logic                  wr_ok;
    logic                  zero_a;
    logic                  zero_b;

    // A clear is starting this edge, or one is already running; either blocks writes.
    assign clr_start  = (state == IDLE) && bus.clr_req;
    assign clr_active = clr_start || (state == CLEAR);

`ifdef REGFILE_ZERO_REG_EN
    // Entry 0 is constant zero: never written, never bypassed, always reads 0.
    assign wr_ok  = bus.we && !clr_active && (bus.waddr != '0);
    assign zero_a = (bus.raddr_a == '0);
    assign zero_b = (bus.raddr_b == '0);
`else
    assign wr_ok  = bus.we && !clr_active;
    assign zero_a = 1'b0;
    assign zero_b = 1'b0;
`endif

    // Read data selection: forced zero, write-first bypass, or stored contents.
    always_comb begin
        rd_a = mem[bus.raddr_a];
        rd_b = mem[bus.raddr_b];
        if (zero_a) begin
            rd_a = '0;
        end else if (wr_ok && (bus.waddr == bus.raddr_a)) begin
            rd_a = bus.wdata;
        end
        if (zero_b) begin
            rd_b = '0;
        end else if (wr_ok && (bus.waddr == bus.raddr_b)) begin
            rd_b = bus.wdata;
        end
    end

    // Clear FSM: counter is 0 in IDLE, so the starting edge zeroes entry 0 through mem[counter].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            counter <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state   <= CLEAR;
                        counter <= ADDR_WIDTH'(1);
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (&counter) begin
                        state   <= IDLE;
                        counter <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage: clearing takes priority over writes, which are already gated off while clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_active) begin
            mem[counter] <= '0;
        end else if (wr_ok) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    // Registered read ports; each holds its value while its enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            if (bus.re_a) begin
                rdata_a_q <= rd_a;
            end
            if (bus.re_b) begin
                rdata_b_q <= rd_b;
            end
        end
    end

    assign bus.rdata_a = rdata_a_q;
    assign bus.rdata_b = rdata_b_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_register_file_2r1w.sv
// tb/tb_register_file_2r1w.sv - scoreboard bench for register_file_2r1w (honours REGFILE_ZERO_REG_EN)
module tb_register_file_2r1w;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    register_file_2r1w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    register_file_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] q_a [$];
    logic [DW-1:0] q_b [$];
    logic [DW-1:0] exp_v;

    task automatic idle_inputs();
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
        bus.re_a = 1'b0; bus.raddr_a = '0;
        bus.re_b = 1'b0; bus.raddr_b = '0;
        bus.clr_req = 1'b0;
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        return (ZERO_EN && a == '0) ? '0 : model[a];
    endfunction

    // One idle-state cycle: drive, push expected read data, update model, advance to next negedge.
    task automatic issue(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic ea, input logic [AW-1:0] ra,
                         input logic eb, input logic [AW-1:0] rb);
        logic acc;
        acc = we && !(ZERO_EN && wa == '0);
        bus.we = we; bus.waddr = wa; bus.wdata = wd;
        bus.re_a = ea; bus.raddr_a = ra;
        bus.re_b = eb; bus.raddr_b = rb;
        if (ea) q_a.push_back((acc && wa == ra) ? wd : model_rd(ra));
        if (eb) q_b.push_back((acc && wa == rb) ? wd : model_rd(rb));
        if (acc) model[wa] = wd;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        issue(1'b1, AW'(5), 32'hCAFE_F00D, 1'b0, '0, 1'b0, '0);
        issue(1'b0, '0, '0, 1'b1, AW'(5), 1'b1, AW'(5));
        exp_v = q_a.pop_front(); checks++;
        if (bus.rdata_a !== exp_v) begin failures++; $display("FAIL pre_reset_a got=%h exp=%h", bus.rdata_a, exp_v); end
        exp_v = q_b.pop_front(); checks++;
        if (bus.rdata_b !== exp_v) begin failures++; $display("FAIL pre_reset_b got=%h exp=%h", bus.rdata_b, exp_v); end
        bus.clr_req = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.clr_req = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL pre_reset_busy got=%b exp=1", bus.busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rdata_a !== '0) begin failures++; $display("FAIL async_reset_a got=%h exp=0", bus.rdata_a); end
        checks++;
        if (bus.rdata_b !== '0) begin failures++; $display("FAIL async_reset_b got=%h exp=0", bus.rdata_b); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy got=%b exp=0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b0, '0, '0, 1'b1, AW'(i), 1'b1, AW'(DEPTH - 1 - i));
            exp_v = q_a.pop_front(); checks++;
            if (bus.rdata_a !== exp_v) begin failures++; $display("FAIL reset_read_a addr=%0d got=%h exp=%h", i, bus.rdata_a, exp_v); end
            exp_v = q_b.pop_front(); checks++;
            if (bus.rdata_b !== exp_v) begin failures++; $display("FAIL reset_read_b addr=%0d got=%h exp=%h", DEPTH - 1 - i, bus.rdata_b, exp_v); end
        end
    endtask

    task automatic test_write_read();
        logic [AW-1:0] a;
        issue(1'b1, AW'(7), 32'hDEAD_BEEF, 1'b0, '0, 1'b0, '0);
        issue(1'b0, '0, '0, 1'b1, AW'(7), 1'b0, '0);
        exp_v = q_a.pop_front(); checks++;
        if (bus.rdata_a !== exp_v) begin failures++; $display("FAIL wr_rd_7 got=%h exp=%h", bus.rdata_a, exp_v); end
        issue(1'b1, AW'(8), 32'h0BAD_0BAD, 1'b0, AW'(8), 1'b0, '0);
        checks++;
        if (bus.rdata_a !== 32'hDEAD_BEEF) begin failures++; $display("FAIL hold_a got=%h exp=deadbeef", bus.rdata_a); end
        for (int n = 0; n < 8; n++) begin
            a = AW'($urandom_range(1, DEPTH - 1));
            issue(1'b1, a, $urandom, 1'b0, '0, 1'b0, '0);
            issue(1'b0, '0, '0, 1'b1, a, 1'b1, AW'($urandom_range(0, DEPTH - 1)));
            exp_v = q_a.pop_front(); checks++;
            if (bus.rdata_a !== exp_v) begin failures++; $display("FAIL rand_rd_a addr=%0d got=%h exp=%h", a, bus.rdata_a, exp_v); end
            exp_v = q_b.pop_front(); checks++;
            if (bus.rdata_b !== exp_v) begin failures++; $display("FAIL rand_rd_b got=%h exp=%h", bus.rdata_b, exp_v); end
        end
    endtask

    task automatic test_bypass();
        issue(1'b1, AW'(12), 32'h0000_1234, 1'b1, AW'(12), 1'b1, AW'(12));
        exp_v = q_a.pop_front(); checks++;
        if (bus.rdata_a !== exp_v) begin failures++; $display("FAIL bypass_a got=%h exp=%h", bus.rdata_a, exp_v); end
        exp_v = q_b.pop_front(); checks++;
        if (bus.rdata_b !== exp_v) begin failures++; $display("FAIL bypass_b got=%h exp=%h", bus.rdata_b, exp_v); end
        issue(1'b1, AW'(13), 32'h5A5A_0013, 1'b1, AW'(7), 1'b1, AW'(13));
        exp_v = q_a.pop_front(); checks++;
        if (bus.rdata_a !== exp_v) begin failures++; $display("FAIL nobypass_a got=%h exp=%h", bus.rdata_a, exp_v); end
        exp_v = q_b.pop_front(); checks++;
        if (bus.rdata_b !== exp_v) begin failures++; $display("FAIL bypass_one_b got=%h exp=%h", bus.rdata_b, exp_v); end
    endtask

    // Clear with a blocked write and mid-clear reads; k counts edges from the starting edge.
    task automatic run_clear(input bit contend);
        int k;
        for (int i = 0; i < DEPTH; i++) issue(1'b1, AW'(i), 32'h1000_0000 + i * 32'h0101_0101, 1'b0, '0, 1'b0, '0);
        bus.clr_req = 1'b1;
        if (contend) begin bus.we = 1'b1; bus.waddr = AW'(3); bus.wdata = 32'h55; end
        @(posedge clk); @(negedge clk);
        idle_inputs();
        k = 1;
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL clr_busy_rise contend=%0d got=%b exp=1", contend, bus.busy); end
        while (bus.busy === 1'b1 && k < 100) begin
            k++;
            if (k == 2 && !contend) begin bus.we = 1'b1; bus.waddr = AW'(31); bus.wdata = 32'hBAD0_BAD0; end
            if (k == 2 && contend) begin bus.re_a = 1'b1; bus.raddr_a = AW'(3); q_a.push_back(model_rd(AW'(3))); end
            if (k == 5 && !contend) begin bus.re_a = 1'b1; bus.raddr_a = AW'(31); q_a.push_back(model[31]); end
            if (k == 10 && contend) bus.clr_req = 1'b1;
            if (k == DEPTH) begin bus.re_b = 1'b1; bus.raddr_b = AW'(31); q_b.push_back(model[31]); end
            @(posedge clk); @(negedge clk);
            idle_inputs();
            if (q_a.size() != 0) begin
                exp_v = q_a.pop_front(); checks++;
                if (bus.rdata_a !== exp_v) begin failures++; $display("FAIL mid_clear_a k=%0d got=%h exp=%h", k, bus.rdata_a, exp_v); end
            end
            if (q_b.size() != 0) begin
                exp_v = q_b.pop_front(); checks++;
                if (bus.rdata_b !== exp_v) begin failures++; $display("FAIL last_entry_old_b k=%0d got=%h exp=%h", k, bus.rdata_b, exp_v); end
            end
        end
        checks++;
        if (k != DEPTH) begin failures++; $display("FAIL clear_len contend=%0d got=%0d exp=%0d", contend, k, DEPTH); end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b0, '0, '0, 1'b1, AW'(i), 1'b0, '0);
            exp_v = q_a.pop_front(); checks++;
            if (bus.rdata_a !== exp_v) begin failures++; $display("FAIL after_clear addr=%0d got=%h exp=%h", i, bus.rdata_a, exp_v); end
        end
    endtask

    task automatic test_clear();
        run_clear(1'b0);
    endtask

    task automatic test_contention();
        run_clear(1'b1);
    endtask

    task automatic test_zero_reg();
        issue(1'b1, '0, 32'hFFFF_FFFF, 1'b1, '0, 1'b1, '0);
        exp_v = q_a.pop_front(); checks++;
        if (bus.rdata_a !== exp_v) begin failures++; $display("FAIL zero_reg_bypass_a got=%h exp=%h", bus.rdata_a, exp_v); end
        exp_v = q_b.pop_front(); checks++;
        if (bus.rdata_b !== exp_v) begin failures++; $display("FAIL zero_reg_bypass_b got=%h exp=%h", bus.rdata_b, exp_v); end
        issue(1'b0, '0, '0, 1'b1, '0, 1'b0, '0);
        exp_v = q_a.pop_front(); checks++;
        if (bus.rdata_a !== exp_v) begin failures++; $display("FAIL zero_reg_read got=%h exp=%h", bus.rdata_a, exp_v); end
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_write_read();
        test_bypass();
        test_clear();
        test_contention();
        test_zero_reg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
